// File: rtl/amo_ocm_unit_if.sv
// Core-side request and OCM-side bus bundle of amo_ocm_unit.
//   slave  : seen by the unit (i_* in, o_* out)
//   master : seen by the core/arbiter/OCM environment
//   i_rd/i_wr/i_is_atomic/i_atomic_op/i_addr/i_dm_write/i_data_from_core/i_opB : core request
//   i_grant/i_data_from_OCM : arbiter grant and OCM read data
//   i_snoop_wr/i_snoop_addr : writes by other OCM masters
//   o_request/o_addr/o_dm_write/o_data_to_OCM : OCM access
//   o_data_to_WB/o_done/o_stall : pipeline side
interface amo_ocm_unit_if #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned DATA_W    = 32
);
  logic                 i_rd;
  logic                 i_wr;
  logic                 i_is_atomic;
  logic [3:0]           i_atomic_op;
  logic [ADDR_BITS-1:0] i_addr;
  logic [3:0]           i_dm_write;
  logic [DATA_W-1:0]    i_data_from_core;
  logic [DATA_W-1:0]    i_opB;
  logic                 i_grant;
  logic [DATA_W-1:0]    i_data_from_OCM;
  logic                 i_snoop_wr;
  logic [ADDR_BITS-1:0] i_snoop_addr;
  logic                 o_request;
  logic [ADDR_BITS-1:0] o_addr;
  logic [3:0]           o_dm_write;
  logic [DATA_W-1:0]    o_data_to_OCM;
  logic [DATA_W-1:0]    o_data_to_WB;
  logic                 o_done;
  logic                 o_stall;

  modport slave (
    input  i_rd, i_wr, i_is_atomic, i_atomic_op, i_addr, i_dm_write,
           i_data_from_core, i_opB, i_grant, i_data_from_OCM,
           i_snoop_wr, i_snoop_addr,
    output o_request, o_addr, o_dm_write, o_data_to_OCM, o_data_to_WB,
           o_done, o_stall
  );

  modport master (
    output i_rd, i_wr, i_is_atomic, i_atomic_op, i_addr, i_dm_write,
           i_data_from_core, i_opB, i_grant, i_data_from_OCM,
           i_snoop_wr, i_snoop_addr,
    input  o_request, o_addr, o_dm_write, o_data_to_OCM, o_data_to_WB,
           o_done, o_stall
  );
endinterface

// File: rtl/amo_ocm_unit.sv
// MEM-stage OCM access unit: arbitrates plain loads/stores and executes
// RV32A AMOs and LR/SC against the shared on-chip memory.
//   clk, nrst : clock, synchronous active-low reset
//   bus       : amo_ocm_unit_if.slave (core request, OCM grant/data, snoop,
//               OCM access outputs, writeback/done/stall)
module amo_ocm_unit #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned DATA_W    = 32
) (
  input  logic          clk,
  input  logic          nrst,
  amo_ocm_unit_if.slave bus
);

  localparam int unsigned WORD_W = ADDR_BITS - 2;

  localparam logic [3:0] OP_SWAP = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_MIN  = 4'd6;
  localparam logic [3:0] OP_MAX  = 4'd7;
  localparam logic [3:0] OP_MINU = 4'd8;
  localparam logic [3:0] OP_MAXU = 4'd9;
  localparam logic [3:0] OP_LR   = 4'd10;
  localparam logic [3:0] OP_SC   = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] temp_q;
  logic              rsv_valid_q, rsv_valid_d;
  logic [WORD_W-1:0] rsv_word_q, rsv_word_d;
  logic              sc_fail_q;

  logic              req, idle_like, granted;
  logic              is_lr, is_sc, is_amo, amo_valid, is_store, is_load;
  logic              snoop_hits_word, sc_hit;
  logic [WORD_W-1:0] word, snoop_word;
  logic [DATA_W-1:0] res;
  logic              unused_addr_lsb;

  // Request decode; inputs are held stable by the stalled pipeline.
  assign req        = bus.i_rd | bus.i_wr | bus.i_is_atomic;
  assign idle_like  = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign granted    = idle_like & req & bus.i_grant;
  assign is_lr      = bus.i_is_atomic & (bus.i_atomic_op == OP_LR);
  assign is_sc      = bus.i_is_atomic & (bus.i_atomic_op == OP_SC);
  assign is_amo     = bus.i_is_atomic & ~is_lr & ~is_sc;
  assign amo_valid  = is_amo & (bus.i_atomic_op >= OP_SWAP) & (bus.i_atomic_op <= OP_MAXU);
  assign is_store   = ~bus.i_is_atomic & bus.i_wr;
  assign is_load    = ~bus.i_is_atomic & ~bus.i_wr & bus.i_rd;
  assign word       = bus.i_addr[ADDR_BITS-1:2];
  assign snoop_word = bus.i_snoop_addr[ADDR_BITS-1:2];
  assign unused_addr_lsb = ^bus.i_snoop_addr[1:0];

  // A snoop to the SC word in the WRITE cycle wins over the SC.
  assign snoop_hits_word = bus.i_snoop_wr & (snoop_word == word);
  assign sc_hit = is_sc & rsv_valid_q & (rsv_word_q == word) & ~snoop_hits_word;

  // AMO result from the old memory value and rs2.
  always_comb begin
    res = temp_q;
    case (bus.i_atomic_op)
      OP_SWAP: res = bus.i_opB;
      OP_ADD:  res = temp_q + bus.i_opB;
      OP_XOR:  res = temp_q ^ bus.i_opB;
      OP_AND:  res = temp_q & bus.i_opB;
      OP_OR:   res = temp_q | bus.i_opB;
      OP_MIN:  res = ($signed(temp_q) < $signed(bus.i_opB)) ? temp_q : bus.i_opB;
      OP_MAX:  res = ($signed(temp_q) > $signed(bus.i_opB)) ? temp_q : bus.i_opB;
      OP_MINU: res = (temp_q < bus.i_opB) ? temp_q : bus.i_opB;
      OP_MAXU: res = (temp_q > bus.i_opB) ? temp_q : bus.i_opB;
      default: res = temp_q;
    endcase
  end

  // Reservation: set by LR, dropped by SC and by any write to its word.
  always_comb begin
    rsv_valid_d = rsv_valid_q;
    rsv_word_d  = rsv_word_q;
    if ((state_q == S_READ) && is_lr) begin
      rsv_valid_d = 1'b1;
      rsv_word_d  = word;
    end
    if ((state_q == S_WRITE) && is_sc) rsv_valid_d = 1'b0;
    if (granted && is_store && (word == rsv_word_d)) rsv_valid_d = 1'b0;
    if ((state_q == S_WRITE) && amo_valid && (word == rsv_word_d)) rsv_valid_d = 1'b0;
    if (bus.i_snoop_wr && (snoop_word == rsv_word_d)) rsv_valid_d = 1'b0;
  end

  // Access sequencing.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      temp_q      <= '0;
      rsv_valid_q <= 1'b0;
      rsv_word_q  <= '0;
      sc_fail_q   <= 1'b0;
    end else begin
      rsv_valid_q <= rsv_valid_d;
      rsv_word_q  <= rsv_word_d;
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (!req)                  state_q <= S_IDLE;
          else if (!bus.i_grant)     state_q <= S_WAIT;
          else if (!bus.i_is_atomic) state_q <= S_DONE;
          else if (is_sc)            state_q <= S_WRITE;
          else                       state_q <= S_READ;
        end
        S_READ: begin
          temp_q  <= bus.i_data_from_OCM;
          state_q <= is_lr ? S_DONE : S_WRITE;
        end
        S_WRITE: begin
          sc_fail_q <= ~sc_hit;
          state_q   <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // OCM and pipeline outputs; the reset cycle never writes or completes.
  always_comb begin
    bus.o_addr        = bus.i_addr;
    bus.o_request     = nrst & ((idle_like & req) | (state_q == S_READ) | (state_q == S_WRITE));
    bus.o_dm_write    = 4'b0000;
    if (nrst) begin
      if (granted && is_store) bus.o_dm_write = bus.i_dm_write;
      if ((state_q == S_WRITE) && (amo_valid || sc_hit)) bus.o_dm_write = 4'b1111;
    end
    bus.o_data_to_OCM = is_sc ? bus.i_opB : (is_amo ? res : bus.i_data_from_core);
    bus.o_data_to_WB  = '0;
    if (state_q == S_DONE) begin
      if (is_load)               bus.o_data_to_WB = bus.i_data_from_OCM;
      else if (is_sc)            bus.o_data_to_WB = DATA_W'(sc_fail_q);
      else if (bus.i_is_atomic)  bus.o_data_to_WB = temp_q;
    end
    bus.o_stall = req & (state_q != S_DONE);
    bus.o_done  = nrst & (state_q == S_DONE);
  end

endmodule
